// File: rtl/spi_master.sv
// SPI master: one 8-bit frame per start, spcon-compatible mode bits, divided SCK.
// Defining SPI_MASTER_LSB_FIRST_EN enables LSB-first ordering via spcon_m[3].
module spi_master #(
    parameter int unsigned HALF_MIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_m,
    input  logic [7:0] spcon_m,
    output logic       busy,
    output logic       tr_done_m,
    output logic [7:0] data_r_m,
    output logic       mosi,
    input  logic       miso,
    output logic       sck,
    output logic       ssn
);
    localparam int unsigned TW = $clog2(HALF_MIN * 8);
    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_t;

    function automatic logic [TW-1:0] half_m1(input logic [1:0] spr);
        half_m1 = TW'((HALF_MIN << spr) - 32'd1);
    endfunction

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s, hm1_r, hm1_s;
    logic [4:0]    edge_r, edge_s, edge_n_s;
    logic [7:0]    tx_r, tx_s, rx_r, rx_s, rdata_r, rdata_s;
    logic          cpha_r, cpha_s;
    logic          busy_r, busy_s, done_r, done_s;
    logic          mosi_r, mosi_s, sck_r, sck_s, ssn_r, ssn_s;
    logic          accept_s;
    logic [7:0]    tx_first_s, rx_out_s;
    logic          unused_s;

    assign accept_s = (state_r == IDLE) && start && !done_r;
    assign edge_n_s = edge_r + 5'd1;

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        for (int i = 0; i < 8; i++) bit_rev[i] = v[7-i];
    endfunction

    logic lsb_r;

    // Frame bit order, captured with the rest of the frame configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsb_r <= 1'b0;
        end else if (accept_s) begin
            lsb_r <= spcon_m[3];
        end else begin
            lsb_r <= lsb_r;
        end
    end

    // The shifters always run MSB-first; LSB-first is a reversal at both ends
    assign tx_first_s = spcon_m[3] ? bit_rev(data_m) : data_m;
    assign rx_out_s   = lsb_r ? bit_rev(rx_r) : rx_r;
    assign unused_s   = ^{spcon_m[5:4], spcon_m[0]};
`else
    assign tx_first_s = data_m;
    assign rx_out_s   = rx_r;
    assign unused_s   = ^{spcon_m[5:3], spcon_m[0]};
`endif

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        hm1_s   = hm1_r;
        edge_s  = edge_r;
        tx_s    = tx_r;
        rx_s    = rx_r;
        rdata_s = rdata_r;
        cpha_s  = cpha_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        mosi_s  = mosi_r;
        sck_s   = sck_r;
        ssn_s   = ssn_r;
        case (state_r)
            IDLE: begin
                sck_s = spcon_m[2];
                if (accept_s) begin
                    cpha_s  = spcon_m[1];
                    hm1_s   = half_m1(spcon_m[7:6]);
                    timer_s = half_m1(spcon_m[7:6]);
                    edge_s  = 5'd0;
                    rx_s    = 8'h00;
                    ssn_s   = 1'b0;
                    busy_s  = 1'b1;
                    state_s = SETUP;
                    if (!spcon_m[1]) begin
                        mosi_s = tx_first_s[7];
                        tx_s   = {tx_first_s[6:0], 1'b0};
                    end else begin
                        tx_s   = tx_first_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (timer_r == T_ZERO) begin
                    timer_s = hm1_r;
                    state_s = XFER;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            XFER: begin
                if (timer_r == T_ZERO) begin
                    timer_s = hm1_r;
                    sck_s   = ~sck_r;
                    edge_s  = edge_n_s;
                    // Sampling edges are odd for cpha=0 and even for cpha=1
                    if (edge_n_s[0] ^ cpha_r) begin
                        rx_s = {rx_r[6:0], miso};
                    end else if (edge_n_s != 5'd16) begin
                        mosi_s = tx_r[7];
                        tx_s   = {tx_r[6:0], 1'b0};
                    end else begin
                        mosi_s = mosi_r;
                    end
                    if (edge_n_s == 5'd16) begin
                        state_s = HOLD;
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            HOLD: begin
                if (timer_r == T_ZERO) begin
                    ssn_s   = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    rdata_s = rx_out_s;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r - T_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            timer_r <= T_ZERO;
            hm1_r   <= T_ZERO;
            edge_r  <= 5'd0;
            tx_r    <= 8'h00;
            rx_r    <= 8'h00;
            rdata_r <= 8'h00;
            cpha_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mosi_r  <= 1'b0;
            sck_r   <= 1'b0;
            ssn_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            hm1_r   <= hm1_s;
            edge_r  <= edge_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            rdata_r <= rdata_s;
            cpha_r  <= cpha_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            mosi_r  <= mosi_s;
            sck_r   <= sck_s;
            ssn_r   <= ssn_s;
        end
    end

    assign busy      = busy_r;
    assign tr_done_m = done_r;
    assign data_r_m  = rdata_r;
    assign mosi      = mosi_r;
    assign sck       = sck_r;
    assign ssn       = ssn_r;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI slave model on mosi/miso.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_m;
    logic [7:0] spcon_m;
    logic       busy, tr_done_m, mosi, sck, ssn;
    logic [7:0] data_r_m;
    logic       miso = 1'b0;

    always #5 clk = ~clk;

    spi_master #(.HALF_MIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_m(data_m), .spcon_m(spcon_m),
        .busy(busy), .tr_done_m(tr_done_m), .data_r_m(data_r_m),
        .mosi(mosi), .miso(miso), .sck(sck), .ssn(ssn)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_exp_done = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] slv;
        int         lat;
        int         t0;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    // Slave model: loads miso at select / drive edges, samples mosi on sampling edges
    logic [7:0] s_tx = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic       prev_sck = 1'b0, prev_ssn = 1'b1;
    int         s_edges = 0;
    int         edge_t[0:31];

    always @(negedge clk) begin
        if (prev_ssn && !ssn) begin
            s_edges <= 0;
            s_rx    <= 8'h00;
            if (!s_cpha) begin
                miso <= s_lsb ? s_tx[0] : s_tx[7];
                s_sh <= (s_lsb ? rev8(s_tx) : s_tx) << 1;
            end else begin
                s_sh <= s_lsb ? rev8(s_tx) : s_tx;
            end
        end else if (!ssn && (sck != prev_sck)) begin
            if (s_edges < 32) edge_t[s_edges] <= cyc;
            s_edges <= s_edges + 1;
            if ((sck != s_cpol) != s_cpha) begin
                s_rx <= s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
            end else begin
                miso <= s_sh[7];
                s_sh <= s_sh << 1;
            end
        end
        prev_sck <= sck;
        prev_ssn <= ssn;
    end

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tr_done_m) begin
            n_done <= n_done + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_r_m", {24'd0, data_r_m}, {24'd0, e.rx});
                check("slave_rx", {24'd0, s_rx}, {24'd0, e.slv});
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    function automatic logic lsb_sel(input logic [7:0] cfg);
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_sel = cfg[3];
`else
        lsb_sel = 1'b0;
`endif
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic [7:0] cfg, input logic [7:0] sbyte,
                               input bit push, input int lat);
        exp_t e;
        s_tx   = sbyte;
        s_cpol = cfg[2];
        s_cpha = cfg[1];
        s_lsb  = lsb_sel(cfg);
        @(negedge clk);
        data_m  = d;
        spcon_m = cfg;
        start   = 1'b1;
        if (push) begin
            e.rx  = sbyte;
            e.slv = d;
            e.lat = lat;
            e.t0  = cyc + 1;
            exp_q.push_back(e);
            n_exp_done++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int busy_low);
        bit seen;
        seen = 1'b0;
        busy_low = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (tr_done_m) seen = 1'b1;
            else if (!busy) busy_low++;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_edges(input int h);
        check("edge_count", s_edges, 32'd16);
        for (int i = 1; i < 16; i++) check("edge_spacing", edge_t[i] - edge_t[i-1], h);
    endtask

    initial begin
        int bl;
        logic m0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_m  = 8'h00;
        spcon_m = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, tr_done_m}, 32'd0);
        check("rst_data", {24'd0, data_r_m}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_ssn", {31'd0, ssn}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset after edge 5 aborts the frame with no done and no data update
        start_frame(8'h5A, 8'h00, 8'hC3, 1'b0, 0);
        for (int i = 0; i < 200 && s_edges < 5; i++) @(negedge clk);
        check("abort_edges_reached", {31'd0, s_edges >= 5}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ssn", {31'd0, ssn}, 32'd1);
        check("abort_sck", {31'd0, sck}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_data", {24'd0, data_r_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_done", n_done, 32'd0);

        // cpol change in IDLE appears on sck one cycle later
        m0 = mosi;
        spcon_m = 8'h04;
        @(posedge clk);
        #1;
        check("idle_sck_cpol", {31'd0, sck}, 32'd1);
        check("idle_ssn", {31'd0, ssn}, 32'd1);
        check("idle_mosi", {31'd0, mosi}, {31'd0, m0});
        @(negedge clk);
        spcon_m = 8'h00;
        repeat (2) @(negedge clk);

        // Mode 0, H=4; start during the done cycle is ignored
        check("mode0_idle_sck", {31'd0, sck}, 32'd0);
        start_frame(8'hA5, 8'h00, 8'h3C, 1'b1, 72);
        check("mode0_first_mosi", {31'd0, mosi}, 32'd1);
        wait_done(200, bl);
        start  = 1'b1;
        data_m = 8'h11;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start_busy", {31'd0, busy}, 32'd0);
        check("done_cycle_start_ssn", {31'd0, ssn}, 32'd1);
        check_edges(4);

        // Mode 3, H=16
        spcon_m = 8'h86;
        repeat (2) @(negedge clk);
        check("mode3_idle_sck", {31'd0, sck}, 32'd1);
        start_frame(8'h81, 8'h86, 8'h7E, 1'b1, 288);
        wait_done(400, bl);
        check_edges(16);
        check("mode3_end_sck", {31'd0, sck}, 32'd1);

        // Start while busy (with new data and config) is ignored
        start_frame(8'hA5, 8'h00, 8'h3C, 1'b1, 72);
        repeat (8) @(negedge clk);
        start   = 1'b1;
        data_m  = 8'hFF;
        spcon_m = 8'hC6;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, bl);
        check("busy_held", bl, 32'd0);
        spcon_m = 8'h00;
        repeat (100) @(negedge clk);

`ifdef SPI_MASTER_LSB_FIRST_EN
        start_frame(8'h01, 8'h08, 8'h01, 1'b1, 72);
        check("lsb_first_mosi", {31'd0, mosi}, 32'd1);
        wait_done(200, bl);
        repeat (4) @(negedge clk);
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        check("done_count", n_done, n_exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
